// File: rtl/radix4_approx_pkg.sv
// Shared types and sizes for the radix-4 Booth approximate multiplier.
// The digit encoder maps one overlapping 3-bit multiplier window to its Booth digit.
package radix4_approx_pkg;

    localparam int NUM_PP    = 9;
    localparam int PP_WIDTH  = 18;
    localparam int SUM_WIDTH = 34;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_e;

    // Window is {y[2i+1], y[2i], y[2i-1]}; digit = -2*b2 + b1 + b0.
    function automatic booth_digit_e booth_encode(input logic [2:0] win);
        booth_digit_e d;
        case (win)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// One radix-4 Booth partial product: d*x as an 18-bit two's complement word,
// where d in {-2,-1,0,1,2} comes from a 3-bit window of the multiplier.
module booth_r4_pp_gen
    import radix4_approx_pkg::*;
(
    input  logic [15:0]                x,
    input  logic [2:0]                 y_win,
    output logic signed [PP_WIDTH-1:0] pp
);

    booth_digit_e                w_digit;
    logic signed [PP_WIDTH-1:0]  w_x1;
    logic signed [PP_WIDTH-1:0]  w_x2;

    assign w_digit = booth_encode(y_win);
    assign w_x1    = {2'b00, x};
    assign w_x2    = {1'b0, x, 1'b0};

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        pp = '0;
        case (w_digit)
            POS1:    pp = w_x1;
            POS2:    pp = w_x2;
            NEG1:    pp = -w_x1;
            NEG2:    pp = -w_x2;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/radix4_approx.sv
// Registered 16x16 approximate multiplier: Booth radix-4 partial products with the
// low APPROX_COLS columns truncated, constant rounding compensation, zero bypass and clamp.
module radix4_approx
    import radix4_approx_pkg::*;
#(
    parameter int APPROX_COLS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        valid_o,
    output logic [31:0] p
);

    localparam logic [SUM_WIDTH-1:0] COL_MASK  = ~((SUM_WIDTH'(1) << APPROX_COLS) - SUM_WIDTH'(1));
    localparam int                   COMP_SHIFT = (APPROX_COLS > 0) ? APPROX_COLS - 1 : 0;
    localparam logic [SUM_WIDTH-1:0] COMP       = (APPROX_COLS > 0) ? (SUM_WIDTH'(1) << COMP_SHIFT) : '0;

    logic [18:0]                w_y_ext;
    logic signed [PP_WIDTH-1:0] w_pp [NUM_PP];
    logic [SUM_WIDTH-1:0]       w_sum;
    logic [SUM_WIDTH-1:0]       w_comp;
    logic [31:0]                w_result;
    logic                       r_valid;
    logic [31:0]                r_p;

    assign w_y_ext = {2'b00, y, 1'b0};

    for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
        booth_r4_pp_gen u_pp (
            .x     (x),
            .y_win (w_y_ext[2*i +: 3]),
            .pp    (w_pp[i])
        );
    end

    // Sign-extend, align to column 2i, truncate the low columns, accumulate mod 2^34.
    always_comb begin
        logic [SUM_WIDTH-1:0] v_term;
        w_sum = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            v_term = {{(SUM_WIDTH - PP_WIDTH){w_pp[i][PP_WIDTH-1]}}, w_pp[i]};
            v_term = (v_term << (2 * i)) & COL_MASK;
            w_sum  = w_sum + v_term;
        end
    end

    assign w_comp = w_sum + COMP;

    // Bit 32 can never be set for a non-negative result; saturate rather than wrap if it were.
    always_comb begin
        w_result = w_comp[31:0];
        if ((x == 16'd0) || (y == 16'd0) || w_comp[SUM_WIDTH-1]) begin
            w_result = '0;
        end else if (w_comp[32]) begin
            w_result = '1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_p     <= '0;
        end else if (valid_i) begin
            r_valid <= 1'b1;
            r_p     <= w_result;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o = r_valid;
    assign p       = r_p;

endmodule

// File: tb/tb_radix4_approx.sv
// Self-checking bench: four multipliers (APPROX_COLS = 0, 4, 8, 16) share one stimulus
// stream and are compared against an arithmetic Booth/truncation reference model.
module tb_radix4_approx;

    localparam int NDUT = 4;
    localparam int K [NDUT] = '{0, 4, 8, 16};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        v_arr [NDUT];
    logic [31:0] p_arr [NDUT];

    longint exp_p [NDUT];
    int     n_checks = 0;
    int     n_errors = 0;

    always #5 clk = ~clk;

    radix4_approx #(.APPROX_COLS(0)) u_dut0 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .x(x), .y(y), .valid_o(v_arr[0]), .p(p_arr[0]));
    radix4_approx #(.APPROX_COLS(4)) u_dut4 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .x(x), .y(y), .valid_o(v_arr[1]), .p(p_arr[1]));
    radix4_approx #(.APPROX_COLS(8)) u_dut8 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .x(x), .y(y), .valid_o(v_arr[2]), .p(p_arr[2]));
    radix4_approx #(.APPROX_COLS(16)) u_dut16 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .x(x), .y(y), .valid_o(v_arr[3]), .p(p_arr[3]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: integer Booth digits, exact d*x*4^i, floored to a multiple of 2^k.
    function automatic longint model(input int k, input longint xv, input longint yv);
        longint s = 0;
        longint w;
        longint m;
        longint r;
        int     d;
        if (xv == 0 || yv == 0) return 0;
        m = longint'(1) << k;
        for (int i = 0; i < 9; i++) begin
            d = -2 * int'((yv >> (2*i+1)) & 1) + int'((yv >> (2*i)) & 1);
            if (i > 0) d += int'((yv >> (2*i-1)) & 1);
            w = longint'(d) * xv * (longint'(1) << (2*i));
            r = ((w % m) + m) % m;
            s += w - r;
        end
        if (k > 0) s += longint'(1) << (k - 1);
        return (s < 0) ? 0 : s;
    endfunction

    task automatic cycle(input logic v, input logic [15:0] xx, input logic [15:0] yy, input logic r);
        longint prod;
        longint diff;
        longint bound;
        logic   exp_v;
        valid_i = v;
        x       = xx;
        y       = yy;
        rst     = r;
        @(posedge clk);
        #1;
        prod  = longint'(xx) * longint'(yy);
        exp_v = v & ~r;
        for (int j = 0; j < NDUT; j++) begin
            if (r)      exp_p[j] = 0;
            else if (v) exp_p[j] = model(K[j], longint'(xx), longint'(yy));
            check($sformatf("valid_k%0d", K[j]), 64'(v_arr[j]), 64'(exp_v));
            check($sformatf("p_k%0d x=%0d y=%0d", K[j], xx, yy), 64'(p_arr[j]), 64'(exp_p[j]));
            if (exp_v) begin
                if (K[j] == 0) begin
                    check("exact_k0", 64'(p_arr[0]), 64'(prod));
                end else begin
                    diff  = longint'(p_arr[j]) - prod;
                    if (diff < 0) diff = -diff;
                    bound = 9 * ((longint'(1) << K[j]) - 1) + (longint'(1) << (K[j] - 1));
                    check($sformatf("bound_k%0d", K[j]), 64'(diff <= bound), 64'd1);
                end
            end
        end
        rst = 1'b0;
    endtask

    function automatic logic [15:0] pick_operand();
        int sel = $urandom_range(0, 15);
        if (sel == 0) return 16'h0000;
        if (sel == 1) return 16'hFFFF;
        if (sel == 2) return 16'(1 << $urandom_range(0, 15));
        return 16'($urandom);
    endfunction

    initial begin
        for (int j = 0; j < NDUT; j++) exp_p[j] = 0;

        cycle(1'b1, 16'd1234, 16'd4321, 1'b1);
        cycle(1'b1, 16'd1234, 16'd4321, 1'b1);

        cycle(1'b1, 16'd256, 16'd256, 1'b0);
        check("tp_256x256_k8", 64'(p_arr[2]), 64'd65664);
        cycle(1'b1, 16'd1, 16'd2, 1'b0);
        check("tp_clamp_k8", 64'(p_arr[2]), 64'd0);
        cycle(1'b1, 16'd0, 16'd12345, 1'b0);
        check("tp_bypass_k8", 64'(p_arr[2]), 64'd0);

        cycle(1'b1, 16'd3, 16'd5, 1'b0);
        check("tp_3x5_k0", 64'(p_arr[0]), 64'd15);
        cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        check("tp_max_k0", 64'(p_arr[0]), 64'd4294836225);
        cycle(1'b1, 16'd1234, 16'd4321, 1'b0);
        check("tp_1234x4321_k0", 64'(p_arr[0]), 64'd5332114);

        cycle(1'b0, 16'd9, 16'd9, 1'b0);
        check("hold_k0", 64'(p_arr[0]), 64'd5332114);

        cycle(1'b1, 16'd2, 16'd3, 1'b0);
        cycle(1'b1, 16'd256, 16'd256, 1'b0);
        check("b2b_256_k8", 64'(p_arr[2]), 64'd65664);
        cycle(1'b1, 16'd0, 16'd7, 1'b0);
        cycle(1'b0, 16'd5, 16'd5, 1'b0);

        cycle(1'b1, 16'd40000, 16'd50000, 1'b0);
        cycle(1'b1, 16'd100, 16'd100, 1'b1);
        check("midreset_p_k8", 64'(p_arr[2]), 64'd0);

        for (int n = 0; n < 10000; n++) begin
            cycle(($urandom_range(0, 7) != 0), pick_operand(), pick_operand(), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
